// File: rtl/triangle_host_if.sv
// Bundle of producer, rasterizer and consumer signals around triangle_host.
// slave = the host block itself, master = whatever drives it (harness/rasterizer side).
interface triangle_host_if;
  logic        tri_valid;
  logic        tri_ready;
  logic [17:0] tri_data;
  logic        nt;
  logic [2:0]  xi;
  logic [2:0]  yi;
  logic        busy;
  logic        po;
  logic [2:0]  xo;
  logic [2:0]  yo;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] res_bitmap;
  logic [6:0]  res_count;
  logic        res_err;
  logic        res_dup;

  modport slave (
    input  tri_valid, tri_data, busy, po, xo, yo, res_ready,
    output tri_ready, nt, xi, yi, res_valid, res_bitmap, res_count, res_err, res_dup
  );

  modport master (
    output tri_valid, tri_data, busy, po, xo, yo, res_ready,
    input  tri_ready, nt, xi, yi, res_valid, res_bitmap, res_count, res_err, res_dup
  );
endinterface

// File: rtl/triangle_host.sv
// Triangle FIFO + vertex serialiser + pixel collector for the rasterizer port.
// Optional duplicate-pixel detection is built when TRIANGLE_HOST_DUP_CHECK_EN is defined.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | waiting for a queued triangle and an idle rasterizer
// ST_SEND1   | nt=1, vertex 1 on xi/yi
// ST_SEND2   | vertex 2 on xi/yi
// ST_SEND3   | vertex 3 on xi/yi
// ST_COLLECT | recording po/xo/yo until busy falls or the timeout hits
// ST_DONE    | result presented on res_*, waiting for res_ready
module triangle_host #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  triangle_host_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND1,
    ST_SEND2,
    ST_SEND3,
    ST_COLLECT,
    ST_DONE
  } state_t;

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [17:0]   mem_q [DEPTH];
  logic [17:0]   mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tri_ready_q, tri_ready_d;

  state_t        state_q, state_d;
  logic [11:0]   tri_q, tri_d;
  logic          nt_q, nt_d;
  logic [2:0]    xi_q, xi_d;
  logic [2:0]    yi_q, yi_d;
  logic [63:0]   bitmap_q, bitmap_d;
  logic [6:0]    count_q, count_d;
  logic          err_q, err_d;
  logic          busy_seen_q, busy_seen_d;
  logic [TW-1:0] to_q, to_d;
  logic          res_valid_q, res_valid_d;
`ifdef TRIANGLE_HOST_DUP_CHECK_EN
  logic          dup_q, dup_d;
`endif

  logic          push;
  logic          pop;
  logic          fifo_empty;
  logic [17:0]   head;
  logic [5:0]    pix_idx;

  assign push       = bus.tri_valid && tri_ready_q;
  assign fifo_empty = (cnt_q == '0);
  assign head       = mem_q[rd_ptr_q];
  assign pix_idx    = {bus.yo, bus.xo};

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = bus.tri_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    tri_ready_d = (cnt_d != CW'(DEPTH));
  end

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    tri_d       = tri_q;
    nt_d        = 1'b0;
    xi_d        = xi_q;
    yi_d        = yi_q;
    bitmap_d    = bitmap_q;
    count_d     = count_q;
    err_d       = err_q;
    busy_seen_d = busy_seen_q;
    to_d        = to_q;
    res_valid_d = 1'b0;
`ifdef TRIANGLE_HOST_DUP_CHECK_EN
    dup_d       = dup_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !bus.busy) begin
          pop         = 1'b1;
          tri_d       = head[11:0];
          nt_d        = 1'b1;
          xi_d        = head[17:15];
          yi_d        = head[14:12];
          bitmap_d    = '0;
          count_d     = '0;
          err_d       = 1'b0;
          busy_seen_d = 1'b0;
          to_d        = '0;
`ifdef TRIANGLE_HOST_DUP_CHECK_EN
          dup_d       = 1'b0;
`endif
          state_d     = ST_SEND1;
        end
      end
      ST_SEND1: begin
        xi_d    = tri_q[11:9];
        yi_d    = tri_q[8:6];
        state_d = ST_SEND2;
      end
      ST_SEND2: begin
        xi_d    = tri_q[5:3];
        yi_d    = tri_q[2:0];
        state_d = ST_SEND3;
      end
      ST_SEND3: begin
        state_d = ST_COLLECT;
      end
      ST_COLLECT: begin
        // Pixels are recorded even on the exit cycle so the last po is never lost.
        if (bus.po) begin
`ifdef TRIANGLE_HOST_DUP_CHECK_EN
          if (bitmap_q[pix_idx]) begin
            dup_d = 1'b1;
          end
`endif
          bitmap_d[pix_idx] = 1'b1;
          if (count_q != 7'h7F) begin
            count_d = count_q + 7'd1;
          end
        end
        if (bus.busy) begin
          busy_seen_d = 1'b1;
        end
        to_d = to_q + TW'(1);
        if (busy_seen_q && !bus.busy) begin
          state_d     = ST_DONE;
          res_valid_d = 1'b1;
        end else if (to_q == TW'(TIMEOUT - 1)) begin
          state_d     = ST_DONE;
          err_d       = 1'b1;
          res_valid_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.res_ready) begin
          state_d = ST_IDLE;
        end else begin
          res_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      tri_ready_q <= 1'b1;
      state_q     <= ST_IDLE;
      tri_q       <= '0;
      nt_q        <= 1'b0;
      xi_q        <= '0;
      yi_q        <= '0;
      bitmap_q    <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
      busy_seen_q <= 1'b0;
      to_q        <= '0;
      res_valid_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      tri_ready_q <= tri_ready_d;
      state_q     <= state_d;
      tri_q       <= tri_d;
      nt_q        <= nt_d;
      xi_q        <= xi_d;
      yi_q        <= yi_d;
      bitmap_q    <= bitmap_d;
      count_q     <= count_d;
      err_q       <= err_d;
      busy_seen_q <= busy_seen_d;
      to_q        <= to_d;
      res_valid_q <= res_valid_d;
    end
  end

`ifdef TRIANGLE_HOST_DUP_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dup_q <= 1'b0;
    end else begin
      dup_q <= dup_d;
    end
  end
  assign bus.res_dup = dup_q;
`else
  assign bus.res_dup = 1'b0;
`endif

  assign bus.tri_ready  = tri_ready_q;
  assign bus.nt         = nt_q;
  assign bus.xi         = xi_q;
  assign bus.yi         = yi_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_bitmap = bitmap_q;
  assign bus.res_count  = count_q;
  assign bus.res_err    = err_q;

endmodule

// File: tb/tb_triangle_host.sv
// Directed bench for triangle_host; the rasterizer is played by hand-written steps.
module tb_triangle_host;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  triangle_host_if bus ();

  triangle_host #(.DEPTH(4), .TIMEOUT(255)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

`ifdef TRIANGLE_HOST_DUP_CHECK_EN
  localparam logic DUP_EXP = 1'b1;
`else
  localparam logic DUP_EXP = 1'b0;
`endif

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [17:0] tri_word(input int x1, y1, x2, y2, x3, y3);
    return {3'(x1), 3'(y1), 3'(x2), 3'(y2), 3'(x3), 3'(y3)};
  endfunction

  task automatic push1(input logic [17:0] d);
    bus.tri_valid = 1'b1;
    bus.tri_data  = d;
    tick();
    bus.tri_valid = 1'b0;
  endtask

  task automatic wait_nt(input string tag);
    int n = 0;
    while (bus.nt !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_nt"}, 64'(bus.nt), 64'd1);
  endtask

  task automatic wait_res(input string tag);
    int n = 0;
    while (bus.res_valid !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    chk({tag, "_res_valid"}, 64'(bus.res_valid), 64'd1);
  endtask

  task automatic accept(input string tag);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    chk({tag, "_res_valid_drop"}, 64'(bus.res_valid), 64'd0);
  endtask

  task automatic px(input int x, input int y);
    bus.po   = 1'b1;
    bus.busy = 1'b1;
    bus.xo   = 3'(x);
    bus.yo   = 3'(y);
    tick();
    bus.po   = 1'b0;
  endtask

  task automatic busy_drop();
    bus.busy = 1'b0;
    bus.po   = 1'b0;
    tick();
  endtask

  task automatic do_timeout(input logic busy_lvl, input string tag);
    push1(tri_word(4, 4, 5, 4, 4, 5));
    wait_nt(tag);
    repeat (3) tick();
    bus.busy = busy_lvl;
    repeat (254) tick();
    chk({tag, "_not_yet"}, 64'(bus.res_valid), 64'd0);
    tick();
    chk({tag, "_res_valid"}, 64'(bus.res_valid), 64'd1);
    chk({tag, "_err"}, 64'(bus.res_err), 64'd1);
    chk({tag, "_count"}, 64'(bus.res_count), 64'd0);
    accept(tag);
    bus.busy = 1'b0;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen;

    reset         = 1'b0;
    bus.tri_valid = 1'b0;
    bus.tri_data  = '0;
    bus.busy      = 1'b0;
    bus.po        = 1'b0;
    bus.xo        = '0;
    bus.yo        = '0;
    bus.res_ready = 1'b0;
    repeat (3) tick();
    chk("rst_nt", 64'(bus.nt), 64'd0);
    chk("rst_tri_ready", 64'(bus.tri_ready), 64'd1);
    chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
    chk("rst_count", 64'(bus.res_count), 64'd0);
    chk("rst_bitmap", bus.res_bitmap, 64'd0);
    chk("rst_err", 64'(bus.res_err), 64'd0);
    reset = 1'b1;
    tick();

    // Single triangle, six pixels, busy falls after the last one.
    push1(tri_word(1, 0, 1, 2, 3, 2));
    wait_nt("single");
    chk("single_v1_x", 64'(bus.xi), 64'd1);
    chk("single_v1_y", 64'(bus.yi), 64'd0);
    tick();
    chk("single_v2_nt", 64'(bus.nt), 64'd0);
    chk("single_v2_x", 64'(bus.xi), 64'd1);
    chk("single_v2_y", 64'(bus.yi), 64'd2);
    tick();
    chk("single_v3_x", 64'(bus.xi), 64'd3);
    chk("single_v3_y", 64'(bus.yi), 64'd2);
    tick();
    px(1, 0); px(1, 1); px(2, 1); px(1, 2); px(2, 2); px(3, 2);
    busy_drop();
    chk("single_res_valid", 64'(bus.res_valid), 64'd1);
    chk("single_count", 64'(bus.res_count), 64'd6);
    chk("single_bitmap", bus.res_bitmap, 64'h0000_0000_000E_0602);
    chk("single_err", 64'(bus.res_err), 64'd0);
    chk("single_dup", 64'(bus.res_dup), 64'd0);
    repeat (2) tick();
    chk("single_hold_valid", 64'(bus.res_valid), 64'd1);
    chk("single_hold_xi", 64'(bus.xi), 64'd3);
    accept("single");

    // po outside COLLECT must not touch the held result.
    bus.po = 1'b1; bus.xo = 3'd5; bus.yo = 3'd5;
    repeat (2) tick();
    bus.po = 1'b0;
    chk("idle_po_count", 64'(bus.res_count), 64'd6);
    chk("idle_po_bitmap", bus.res_bitmap, 64'h0000_0000_000E_0602);

    // Final pixel arrives on the same cycle busy falls.
    push1(tri_word(0, 0, 7, 0, 7, 7));
    wait_nt("edge");
    chk("edge_v1_x", 64'(bus.xi), 64'd0);
    repeat (3) tick();
    px(0, 0);
    bus.po = 1'b1; bus.busy = 1'b0; bus.xo = 3'd7; bus.yo = 3'd7;
    tick();
    bus.po = 1'b0;
    chk("edge_res_valid", 64'(bus.res_valid), 64'd1);
    chk("edge_count", 64'(bus.res_count), 64'd2);
    chk("edge_bitmap", bus.res_bitmap, 64'h8000_0000_0000_0001);
    accept("edge");

    // 130 pixels: count saturates at 127, every bitmap bit set.
    push1(tri_word(2, 2, 4, 2, 2, 4));
    wait_nt("sat");
    repeat (3) tick();
    for (int i = 0; i < 130; i++) px(i % 8, (i / 8) % 8);
    busy_drop();
    chk("sat_res_valid", 64'(bus.res_valid), 64'd1);
    chk("sat_count", 64'(bus.res_count), 64'd127);
    chk("sat_bitmap", bus.res_bitmap, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("sat_err", 64'(bus.res_err), 64'd0);
    accept("sat");

    // Same pixel twice.
    push1(tri_word(2, 3, 2, 3, 2, 3));
    wait_nt("dup");
    repeat (3) tick();
    px(2, 3); px(2, 3);
    busy_drop();
    chk("dup_count", 64'(bus.res_count), 64'd2);
    chk("dup_bitmap", bus.res_bitmap, 64'h0000_0000_0400_0000);
    chk("dup_flag", 64'(bus.res_dup), 64'(DUP_EXP));
    accept("dup");

    do_timeout(1'b1, "to_busy_high");
    do_timeout(1'b0, "to_busy_never");

    // Backpressure: six pushes while results are held off.
    bus.tri_valid = 1'b1;
    bus.tri_data  = tri_word(1, 6, 0, 0, 0, 0); tick();
    bus.tri_data  = tri_word(2, 5, 0, 0, 0, 0); tick();
    chk("bp_first_nt", 64'(bus.nt), 64'd1);
    chk("bp_first_x", 64'(bus.xi), 64'd1);
    bus.tri_data  = tri_word(3, 4, 0, 0, 0, 0); tick();
    bus.tri_data  = tri_word(4, 3, 0, 0, 0, 0); tick();
    chk("bp_not_full", 64'(bus.tri_ready), 64'd1);
    bus.tri_data  = tri_word(5, 2, 0, 0, 0, 0); tick();
    chk("bp_full", 64'(bus.tri_ready), 64'd0);
    bus.tri_data  = tri_word(6, 1, 0, 0, 0, 0); tick();
    bus.tri_valid = 1'b0;
    bus.busy = 1'b1; tick();
    busy_drop();
    wait_res("bp_first");
    chk("bp_still_full", 64'(bus.tri_ready), 64'd0);
    accept("bp_first");
    for (int k = 2; k <= 5; k++) begin
      wait_nt($sformatf("bp_q%0d", k));
      chk($sformatf("bp_q%0d_x", k), 64'(bus.xi), 64'(k));
      chk($sformatf("bp_q%0d_y", k), 64'(bus.yi), 64'(7 - k));
      if (k == 2) chk("bp_ready_again", 64'(bus.tri_ready), 64'd1);
      repeat (3) tick();
      bus.busy = 1'b1; tick();
      busy_drop();
      wait_res($sformatf("bp_q%0d", k));
      accept($sformatf("bp_q%0d", k));
    end
    seen = 0;
    repeat (20) begin
      tick();
      if (bus.nt === 1'b1) seen++;
    end
    chk("bp_sixth_dropped", 64'(seen), 64'd0);

    // Reset in the middle of SEND1 with another triangle queued.
    bus.tri_valid = 1'b1;
    bus.tri_data  = tri_word(7, 7, 0, 0, 0, 0); tick();
    bus.tri_data  = tri_word(6, 6, 0, 0, 0, 0); tick();
    bus.tri_valid = 1'b0;
    wait_nt("mid");
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_nt", 64'(bus.nt), 64'd0);
    chk("mid_rst_tri_ready", 64'(bus.tri_ready), 64'd1);
    chk("mid_rst_res_valid", 64'(bus.res_valid), 64'd0);
    tick();
    reset = 1'b1;
    seen = 0;
    repeat (20) begin
      tick();
      if (bus.nt === 1'b1) seen++;
    end
    chk("mid_rst_fifo_empty", 64'(seen), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/triangle_host.md
Name: triangle_host

Overview:
- Upstream-side driver and collector for the triangle rasterizer's nt/xi/yi/busy/po/xo/yo interface.
- Queues triangles from a producer and serialises each one's three vertices onto nt/xi/yi.
- Collects the emitted po/xo/yo pixel stream into an 8x8 bitmap plus a pixel count, then hands the per-triangle result to a consumer.
- Sits between the host/test harness and the rasterizer.

Parameters:
- DEPTH, 4, triangle FIFO entries (power of 2, >=2).
- TIMEOUT, 255, max COLLECT cycles before the triangle is aborted with an error.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- tri_valid  input  1  producer offers a triangle.
- tri_ready  output  1  FIFO not full.
- tri_data  input  18  {x1,y1,x2,y2,x3,y3}, 3 bits each, x1 at MSBs.
- nt  output  1  new-triangle strobe to the rasterizer.
- xi  output  3  vertex x to the rasterizer.
- yi  output  3  vertex y to the rasterizer.
- busy  input  1  rasterizer busy.
- po  input  1  rasterizer pixel valid.
- xo  input  3  pixel x.
- yo  input  3  pixel y.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts the result.
- res_bitmap  output  64  bit index {yo,xo} set for each received pixel.
- res_count  output  7  number of po pulses, saturating at 127.
- res_err  output  1  triangle aborted by timeout.
- res_dup  output  1  duplicate pixel seen (see Optional Feature).

Behaviour:
- Reset (reset=0, async): all outputs 0 except tri_ready=1; FIFO emptied; FSM to IDLE; bitmap, count and timeout counter cleared.
- FIFO: push on tri_valid&&tri_ready. Pop when IDLE leaves for SEND1. Push and pop in the same cycle are both honoured. tri_ready=0 only when DEPTH entries are held; a push while full is ignored.
- FSM states: IDLE, SEND1, SEND2, SEND3, COLLECT, DONE. All outputs are registered.
- IDLE: when FIFO is non-empty and busy==0, pop the head, clear bitmap/count/err/dup, and go to SEND1.
- SEND1: nt=1, xi/yi=x1/y1 for exactly one cycle, then SEND2.
- SEND2: nt=0, xi/yi=x2/y2, then SEND3.
- SEND3: nt=0, xi/yi=x3/y3, then COLLECT. xi/yi hold their last value outside the SEND states.
- COLLECT:
  - Every cycle with po=1: set bitmap[{yo,xo}] and increment count (saturating). This includes the cycle in which busy falls.
  - Track busy_seen: it sets the first cycle busy=1.
  - Exit to DONE on the first cycle with busy_seen && busy==0. A po sampled in that exit cycle is still recorded.
  - The timeout counter increments every COLLECT cycle. Reaching TIMEOUT forces DONE with res_err=1. This also covers busy never rising.
- DONE: res_valid=1, with res_* stable until res_valid&&res_ready. On that cycle res_valid drops and the FSM returns to IDLE. The next SEND1 comes no earlier than the following cycle.
- Nominal nt-to-first-po latency is set by the rasterizer; this block adds none beyond registered outputs.
- po while not in COLLECT is ignored.
- Back-to-back triangles: at least one IDLE cycle separates DONE from the next SEND1.
- Reset mid-operation: everything is discarded, including queued triangles, and nt deasserts asynchronously.

Optional Feature:
- Macro: TRIANGLE_HOST_DUP_CHECK_EN.
- Defined: in COLLECT, a po whose bitmap bit is already set sets res_dup=1 (sticky per triangle). The pixel is still counted.
- Undefined: no duplicate-check logic is built; res_dup is tied to 0.

Test Plan:
- Reset: assert reset=0 mid-run -> nt=0, res_valid=0, tri_ready=1, FIFO empty; after release with no push, nt stays 0.
- Single triangle: push tri_data {1,0,1,2,3,2} with the rasterizer model idle -> SEND1 nt=1 xi=1 yi=0, next cycles (1,2) then (3,2). Model returns 6 pixels (1,0)(1,1)(2,1)(1,2)(2,2)(3,2) -> res_count=6, bits 1,9,10,17,18,19 set, res_err=0.
- Backpressure: hold res_ready=0 and push 6 triangles -> first is popped into service, 4 queued, tri_ready=0 on the 6th attempt; the 6th is not stored; the queued ones drain in order as results are accepted.
- Timeout: model holds busy=1 forever -> after 255 COLLECT cycles res_valid=1, res_err=1; busy never rising gives the same result.
- Last-pixel edge: model emits its final po in the same cycle busy falls -> that pixel is counted and res_count includes it.
- Duplicate (macro defined): model emits (2,3) twice -> res_dup=1, res_count=2; macro undefined -> res_dup=0.
